mem_copy_engine: RTL and testbench

- Memory-side initiator (DMA) that drives one port of the packet simulator's word-addressed RAMs.
- Supported operations:
  - Copy: moves LEN words from SRC to DST.
  - Fill: writes a constant pattern to LEN words at DST.
- Interface and timing: start/busy/done handshake toward the controller. Read data on the memory port is combinational: valid in the same cycle the address and enable are driven.

---
 rtl/mem_copy_engine.sv | 117 +++++++++++
 tb/tb_mem_copy_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Word-granular DMA engine: copies LEN words SRC->DST (read-then-write per word)
// or fills LEN words at DST with a pattern, on a single combinational-read RAM port.
module mem_copy_engine #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int ADDR_WIDTH       = 16,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_in,
    input  logic                        op_in,
    input  logic [ADDR_WIDTH-1:0]       src_in,
    input  logic [ADDR_WIDTH-1:0]       dst_in,
    input  logic [LEN_WIDTH-1:0]        len_in,
    input  logic [MEMORY_BUS_WIDTH-1:0] pattern_in,
    input  logic                        abort_in,
    output logic                        busy_out,
    output logic                        done_out,
    output logic [LEN_WIDTH-1:0]        words_out,
    output logic                        mem_enable_out,
    output logic                        mem_wb_out,
    output logic [ADDR_WIDTH-1:0]       mem_addr_out,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in
);

    typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

    typedef struct packed {
        logic                        op;
        logic [ADDR_WIDTH-1:0]       src;
        logic [ADDR_WIDTH-1:0]       dst;
        logic [LEN_WIDTH-1:0]        len;
        logic [MEMORY_BUS_WIDTH-1:0] pattern;
    } req_t;

    state_t                state, state_nxt;
    req_t                  req;
    logic [MEMORY_BUS_WIDTH-1:0] data_q;
    logic [LEN_WIDTH-1:0]  words;
    logic                  last;

    // words doubles as the per-word index i; last is true on the LEN-th write
    assign last      = ((words + LEN_WIDTH'(1)) == req.len);
    assign words_out = words;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            req    <= '0;
            data_q <= '0;
            words  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start_in) begin
                    req   <= '{op: op_in, src: src_in, dst: dst_in,
                               len: len_in, pattern: pattern_in};
                    words <= '0;
                end
                RD:       data_q <= mem_data_in;
                WR, FILL: words  <= words + LEN_WIDTH'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_in) begin
                if (len_in == '0) state_nxt = DONE;
                else if (op_in)   state_nxt = FILL;
                else              state_nxt = RD;
            end
            // an aborted read is simply dropped; no write follows it
            RD:      state_nxt = abort_in ? DONE : WR;
            WR:      state_nxt = (abort_in || last) ? DONE : RD;
            FILL:    state_nxt = (abort_in || last) ? DONE : FILL;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_out       = 1'b0;
        done_out       = 1'b0;
        mem_enable_out = 1'b0;
        mem_wb_out     = 1'b0;
        mem_addr_out   = '0;
        mem_data_out   = '0;
        case (state)
            RD: begin
                busy_out       = 1'b1;
                mem_enable_out = 1'b1;
                mem_addr_out   = req.src + ADDR_WIDTH'(words);
            end
            WR: begin
                busy_out       = 1'b1;
                mem_enable_out = 1'b1;
                mem_wb_out     = 1'b1;
                mem_addr_out   = req.dst + ADDR_WIDTH'(words);
                mem_data_out   = data_q;
            end
            FILL: begin
                busy_out       = 1'b1;
                mem_enable_out = 1'b1;
                mem_wb_out     = 1'b1;
                mem_addr_out   = req.dst + ADDR_WIDTH'(words);
                mem_data_out   = req.pattern;
            end
            DONE:    done_out = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: behavioural RAM, access log, latency/abort/reset checks.
module tb_mem_copy_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_in, op_in, abort_in;
    logic [15:0] src_in, dst_in, len_in;
    logic [31:0] pattern_in;
    logic        busy_out, done_out;
    logic [15:0] words_out;
    logic        mem_enable_out, mem_wb_out;
    logic [15:0] mem_addr_out;
    logic [31:0] mem_data_out, mem_data_in;

    logic [31:0] ram [0:65535];

    typedef struct {
        logic        wb;
        logic [15:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t acc_q[$];

    int nchecks = 0;
    int nerrors = 0;
    int lat, nbusy;

    mem_copy_engine dut (
        .clock(clock), .reset(reset), .start_in(start_in), .op_in(op_in),
        .src_in(src_in), .dst_in(dst_in), .len_in(len_in), .pattern_in(pattern_in),
        .abort_in(abort_in), .busy_out(busy_out), .done_out(done_out),
        .words_out(words_out), .mem_enable_out(mem_enable_out), .mem_wb_out(mem_wb_out),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
    );

    always #5 clock = ~clock;

    assign mem_data_in = ram[mem_addr_out];

    always @(posedge clock)
        if (mem_enable_out && mem_wb_out) ram[mem_addr_out] <= mem_data_out;

    always @(negedge clock)
        if (mem_enable_out) acc_q.push_back('{mem_wb_out, mem_addr_out, mem_data_out});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        if (obs !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic op, input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input logic [31:0] pat, input logic abt);
        @(negedge clock);
        acc_q.delete();
        op_in = op; src_in = src; dst_in = dst; len_in = len; pattern_in = pat;
        abort_in = abt; start_in = 1'b1;
        @(posedge clock);
        #1 start_in = 1'b0; abort_in = 1'b0;
    endtask

    // cycle k is the k-th cycle after the accepting edge; pulses are held for that one cycle
    task automatic wait_done(input int max, input int abort_at, input int restart_at,
                             output int lt, output int nb);
        lt = -1; nb = 0;
        for (int k = 1; k <= max; k++) begin
            @(negedge clock);
            abort_in = (k == abort_at);
            start_in = (k == restart_at);
            if (k == restart_at) begin
                op_in = 1'b0; len_in = 16'd1;
            end
            if (busy_out) nb++;
            if (done_out) begin
                lt = k;
                break;
            end
        end
        abort_in = 1'b0; start_in = 1'b0;
        if (lt < 0) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b0; start_in = 0; op_in = 0; abort_in = 0;
        src_in = 0; dst_in = 0; len_in = 0; pattern_in = 0;
        for (int i = 0; i < 65536; i++) ram[i] = 32'hFFFF_FFFF;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_done", {31'd0, done_out}, 32'd0);
        check("rst_words", {16'd0, words_out}, 32'd0);
        check("rst_en", {31'd0, mem_enable_out}, 32'd0);
        reset = 1'b1;

        // copy 4 words 0x10 -> 0x40
        for (int i = 0; i < 4; i++) ram[16'h10 + i] = 32'hA0 + i;
        start_op(1'b0, 16'h10, 16'h40, 16'd4, 32'd0, 1'b0);
        wait_done(40, 0, 0, lat, nbusy);
        check("copy_lat", lat, 32'd9);
        check("copy_busy", nbusy, 32'd8);
        check("copy_words", {16'd0, words_out}, 32'd4);
        check("copy_done_en", {31'd0, mem_enable_out}, 32'd0);
        check("copy_nacc", acc_q.size(), 32'd8);
        if (acc_q.size() == 8)
            for (int i = 0; i < 4; i++) begin
                check("copy_rd_addr", {16'd0, acc_q[2*i].addr}, 32'h10 + i);
                check("copy_rd_wb", {31'd0, acc_q[2*i].wb}, 32'd0);
                check("copy_wr_addr", {16'd0, acc_q[2*i+1].addr}, 32'h40 + i);
                check("copy_wr_data", acc_q[2*i+1].data, 32'hA0 + i);
            end
        @(negedge clock);
        for (int i = 0; i < 4; i++) check("copy_ram", ram[16'h40 + i], 32'hA0 + i);

        // fill, with abort raised alongside start (must be ignored)
        start_op(1'b1, 16'h0, 16'h20, 16'd3, 32'hDEADBEEF, 1'b1);
        wait_done(40, 0, 0, lat, nbusy);
        check("fill_lat", lat, 32'd4);
        check("fill_words", {16'd0, words_out}, 32'd3);
        check("fill_nacc", acc_q.size(), 32'd3);
        if (acc_q.size() == 3)
            for (int i = 0; i < 3; i++) check("fill_addr", {16'd0, acc_q[i].addr}, 32'h20 + i);
        @(negedge clock);
        for (int i = 0; i < 3; i++) check("fill_ram", ram[16'h20 + i], 32'hDEADBEEF);

        // zero length
        start_op(1'b0, 16'h10, 16'h50, 16'd0, 32'd0, 1'b0);
        wait_done(10, 0, 0, lat, nbusy);
        check("zero_lat", lat, 32'd1);
        check("zero_busy", nbusy, 32'd0);
        check("zero_nacc", acc_q.size(), 32'd0);
        check("zero_words", {16'd0, words_out}, 32'd0);

        // start during a fill is ignored
        start_op(1'b1, 16'h0, 16'h30, 16'd5, 32'h55, 1'b0);
        wait_done(40, 0, 2, lat, nbusy);
        check("restart_lat", lat, 32'd6);
        check("restart_words", {16'd0, words_out}, 32'd5);
        check("restart_nacc", acc_q.size(), 32'd5);
        @(negedge clock);
        check("restart_idle", {31'd0, busy_out}, 32'd0);
        check("restart_ram", ram[16'h34], 32'h55);

        // address wraparound
        ram[16'hFFFE] = 32'd1; ram[16'hFFFF] = 32'd2; ram[16'h0] = 32'd3; ram[16'h1] = 32'd4;
        start_op(1'b0, 16'hFFFE, 16'h0002, 16'd4, 32'd0, 1'b0);
        wait_done(40, 0, 0, lat, nbusy);
        check("wrap_nacc", acc_q.size(), 32'd8);
        if (acc_q.size() == 8) begin
            check("wrap_rd2", {16'd0, acc_q[4].addr}, 32'h0000);
            check("wrap_rd1", {16'd0, acc_q[2].addr}, 32'hFFFF);
        end
        @(negedge clock);
        for (int i = 0; i < 4; i++) check("wrap_ram", ram[16'h2 + i], 32'd1 + i);

        // overlapping copy replicates the first word
        ram[16'h10] = 32'd7;
        start_op(1'b0, 16'h10, 16'h11, 16'd3, 32'd0, 1'b0);
        wait_done(40, 0, 0, lat, nbusy);
        @(negedge clock);
        for (int i = 1; i < 4; i++) check("ovl_ram", ram[16'h10 + i], 32'd7);

        // abort during 3rd WR (cycle 6)
        for (int i = 0; i < 10; i++) begin
            ram[16'h100 + i] = 32'h1000 + i;
            ram[16'h200 + i] = 32'hFFFF_FFFF;
        end
        start_op(1'b0, 16'h100, 16'h200, 16'd10, 32'd0, 1'b0);
        wait_done(40, 6, 0, lat, nbusy);
        check("abw_lat", lat, 32'd7);
        check("abw_words", {16'd0, words_out}, 32'd3);
        check("abw_nacc", acc_q.size(), 32'd6);
        repeat (3) @(negedge clock);
        check("abw_quiet", acc_q.size(), 32'd6);
        check("abw_ram2", ram[16'h202], 32'h1002);
        check("abw_ram3", ram[16'h203], 32'hFFFF_FFFF);

        // abort during RD of word 4 (cycle 7)
        for (int i = 0; i < 10; i++) ram[16'h200 + i] = 32'hFFFF_FFFF;
        start_op(1'b0, 16'h100, 16'h200, 16'd10, 32'd0, 1'b0);
        wait_done(40, 7, 0, lat, nbusy);
        check("abr_lat", lat, 32'd8);
        check("abr_words", {16'd0, words_out}, 32'd3);
        check("abr_nacc", acc_q.size(), 32'd7);
        if (acc_q.size() == 7) check("abr_last_rd", {31'd0, acc_q[6].wb}, 32'd0);
        @(negedge clock);
        check("abr_ram3", ram[16'h203], 32'hFFFF_FFFF);
        check("abr_ram2", ram[16'h202], 32'h1002);

        // reset mid-fill
        start_op(1'b1, 16'h0, 16'h300, 16'd8, 32'h1234, 1'b0);
        repeat (2) @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("mrst_busy", {31'd0, busy_out}, 32'd0);
        check("mrst_done", {31'd0, done_out}, 32'd0);
        check("mrst_words", {16'd0, words_out}, 32'd0);
        check("mrst_bus", {mem_enable_out, mem_wb_out, 14'd0, mem_addr_out}, 32'd0);
        check("mrst_data", mem_data_out, 32'd0);
        check("mrst_ram2", ram[16'h302], 32'h1234);
        check("mrst_ram3", ram[16'h303], 32'hFFFF_FFFF);
        reset = 1'b1;
        start_op(1'b1, 16'h0, 16'h310, 16'd2, 32'hCAFE, 1'b0);
        wait_done(40, 0, 0, lat, nbusy);
        check("post_lat", lat, 32'd3);
        check("post_words", {16'd0, words_out}, 32'd2);
        @(negedge clock);
        check("post_ram", ram[16'h311], 32'hCAFE);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
